bg_layer_mixer: RTL and testbench

Parametrised multi-layer background compositor for the TinyQV video peripheral. It holds the register bank: control, status, backdrop colour and per-layer scroll shadow registers. Scroll registers are double-buffered and swapped at frame start. It also counts frames, raises a vblank interrupt, and priority-mixes up to four externally generated 2-2-2 RGB layers into the registered `uo_out` PMOD byte. It sits between `video_controller` (timing in) and the per-layer pattern generators (pixels in, scroll offsets out).

---
 rtl/bg_layer_mixer_if.sv | 25 ++
 rtl/bg_layer_mixer.sv | 160 ++++++++++++++++
 tb/tb_bg_layer_mixer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_layer_mixer_if.sv
// Register bus between the TinyQV peripheral fabric and bg_layer_mixer.
//   address      : register byte address
//   data_in      : write data
//   data_write_n : 11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n  : read strobe (reads have no side effects)
//   data_out     : read data, combinational from address
//   data_ready   : always 1
interface bg_layer_mixer_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );
endinterface

// File: rtl/bg_layer_mixer.sv
// Multi-layer background compositor with register bank, double-buffered
// scroll registers, frame counter, vblank interrupt and priority mixer.
//   clk, reset        : clock, asynchronous active-high reset
//   bus               : register bus (slave modport)
//   hsync/vsync/visible : timing from video_controller
//   layer_rgb/opaque  : per-layer pixels {B,G,R} and opacity
//   layer_en          : enables for the layer generators
//   scroll_x/scroll_y : frame-latched scroll offsets per layer
//   frame_count       : frames since enable
//   user_interrupt    : pending vblank interrupt gated by irq_en
//   uo_out            : registered {vsync, hsync, B, G, R}
module bg_layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int SCROLL_W   = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    bg_layer_mixer_if.slave                bus,
    input  logic                           hsync,
    input  logic                           vsync,
    input  logic                           visible,
    input  logic [6*NUM_LAYERS-1:0]        layer_rgb,
    input  logic [NUM_LAYERS-1:0]          layer_opaque,
    output logic [NUM_LAYERS-1:0]          layer_en,
    output logic [SCROLL_W*NUM_LAYERS-1:0] scroll_x,
    output logic [SCROLL_W*NUM_LAYERS-1:0] scroll_y,
    output logic [7:0]                     frame_count,
    output logic                           user_interrupt,
    output logic [7:0]                     uo_out
);
    localparam logic [3:0] LAYER_MASK = 4'((1 << NUM_LAYERS) - 1);

    logic [7:0]          ctrl_q;
    logic                irq_q,       irq_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [5:0]          backdrop_q;
    logic                vs_prev_q;
    logic [7:0]          uo_q,        uo_d;
    logic [SCROLL_W-1:0] sh_x_q  [NUM_LAYERS];
    logic [SCROLL_W-1:0] sh_y_q  [NUM_LAYERS];
    logic [SCROLL_W-1:0] act_x_q [NUM_LAYERS];
    logic [SCROLL_W-1:0] act_y_q [NUM_LAYERS];

    logic        wr;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        frame_start;
    logic [5:0]  colour;
    logic        unused_bits;

    // Read mux; also serves as the old value for partial-width writes.
    always_comb begin
        rdata = '0;
        case (bus.address)
            6'h00:   rdata = {24'b0, ctrl_q};
            6'h04:   rdata = {16'b0, frame_cnt_q, 7'b0, irq_q};
            6'h08:   rdata = {26'b0, backdrop_q};
            default: begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (bus.address == 6'(16 + 4 * i))
                        rdata = {16'(sh_y_q[i]), 16'(sh_x_q[i])};
                end
            end
        endcase
    end

    // Merge written byte lanes over the current register image.
    always_comb begin
        case (bus.data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            2'b10:   wmask = 32'hFFFF_FFFF;
            default: wmask = 32'h0000_0000;
        endcase
        wr    = (bus.data_write_n != 2'b11);
        wdata = (rdata & ~wmask) | (bus.data_in & wmask);
    end

    assign frame_start = vsync & ~vs_prev_q & ctrl_q[0];

    // Frame start sets the interrupt after any W1C so that set wins;
    // disabling clears the count after any increment on the same edge.
    always_comb begin
        irq_d       = irq_q;
        frame_cnt_d = frame_cnt_q;
        if (wr && bus.address == 6'h04 && wdata[0])
            irq_d = 1'b0;
        if (frame_start) begin
            irq_d       = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (wr && bus.address == 6'h00 && !wdata[0])
            frame_cnt_d = 8'd0;
    end

    // Priority mix: scan from the highest index so the lowest opaque wins.
    always_comb begin
        colour = backdrop_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && layer_opaque[i])
                colour = layer_rgb[6*i +: 6];
        end
        if (!ctrl_q[0] || !visible)
            colour = 6'd0;
        uo_d = ctrl_q[0] ? {vsync, hsync, colour} : 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= '0;
            irq_q       <= 1'b0;
            frame_cnt_q <= '0;
            backdrop_q  <= '0;
            vs_prev_q   <= 1'b0;
            uo_q        <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                sh_x_q[i]  <= '0;
                sh_y_q[i]  <= '0;
                act_x_q[i] <= '0;
                act_y_q[i] <= '0;
            end
        end else begin
            vs_prev_q   <= vsync;
            uo_q        <= uo_d;
            irq_q       <= irq_d;
            frame_cnt_q <= frame_cnt_d;
            if (wr && bus.address == 6'h00)
                ctrl_q <= {wdata[7:4] & LAYER_MASK, 2'b00, wdata[1:0]};
            if (wr && bus.address == 6'h08)
                backdrop_q <= wdata[5:0];
            for (int i = 0; i < NUM_LAYERS; i++) begin
                // Active copies take the pre-write shadow on a coincident write.
                if (frame_start) begin
                    act_x_q[i] <= sh_x_q[i];
                    act_y_q[i] <= sh_y_q[i];
                end
                if (wr && bus.address == 6'(16 + 4 * i)) begin
                    sh_x_q[i] <= wdata[SCROLL_W-1:0];
                    sh_y_q[i] <= wdata[16 +: SCROLL_W];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        assign layer_en[gi]                      = ctrl_q[4+gi] & ctrl_q[0];
        assign scroll_x[SCROLL_W*gi +: SCROLL_W] = act_x_q[gi];
        assign scroll_y[SCROLL_W*gi +: SCROLL_W] = act_y_q[gi];
    end

    assign bus.data_out   = rdata;
    assign bus.data_ready = 1'b1;
    assign frame_count    = frame_cnt_q;
    assign user_interrupt = irq_q & ctrl_q[1];
    assign uo_out         = uo_q;

    // Read strobe and dropped high write bits are intentionally not consumed.
    assign unused_bits = ^{bus.data_read_n, wdata};
endmodule

// File: tb/tb_bg_layer_mixer.sv
module tb_bg_layer_mixer;
    localparam int NL = 4;
    localparam int SW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bg_layer_mixer_if bus ();
    logic              hsync, vsync, visible;
    logic [6*NL-1:0]   layer_rgb;
    logic [NL-1:0]     layer_opaque;
    logic [NL-1:0]     layer_en;
    logic [SW*NL-1:0]  scroll_x, scroll_y;
    logic [7:0]        frame_count;
    logic              user_interrupt;
    logic [7:0]        uo_out;

    bg_layer_mixer #(.NUM_LAYERS(NL), .SCROLL_W(SW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .hsync(hsync), .vsync(vsync), .visible(visible),
        .layer_rgb(layer_rgb), .layer_opaque(layer_opaque), .layer_en(layer_en),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .frame_count(frame_count),
        .user_interrupt(user_interrupt), .uo_out(uo_out)
    );

    int tests_run = 0;
    int fails = 0;

    // Reference model: the programmer-visible state of the block.
    logic [31:0]   m_ctrl, m_backdrop;
    logic [31:0]   m_scr [NL];
    logic [SW-1:0] m_ax [NL];
    logic [SW-1:0] m_ay [NL];
    int            m_cnt;
    bit            m_irq;

    localparam logic [31:0] CTRL_FIELDS = 32'h3 | (32'((1 << NL) - 1) << 4);
    localparam logic [31:0] SCR_FIELDS  = 32'((1 << SW) - 1) | (32'((1 << SW) - 1) << 16);

    function automatic void m_reset();
        m_ctrl = 0; m_backdrop = 0; m_cnt = 0; m_irq = 0;
        for (int i = 0; i < NL; i++) begin m_scr[i] = 0; m_ax[i] = 0; m_ay[i] = 0; end
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return m_ctrl;
        if (a == 6'h04) return {16'b0, 8'(m_cnt), 7'b0, m_irq};
        if (a == 6'h08) return m_backdrop;
        if (a >= 6'h10 && int'(a) < 16 + 4 * NL && a[1:0] == 2'b00) return m_scr[(int'(a) - 16) / 4];
        return 32'h0;
    endfunction

    function automatic void m_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        logic [31:0] lanes, nv;
        if (wn == 2'b11) return;
        lanes = (wn == 2'b00) ? 32'hFF : (wn == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        nv = (m_read(a) & ~lanes) | (d & lanes);
        if (a == 6'h00) begin
            m_ctrl = nv & CTRL_FIELDS;
            if (!m_ctrl[0]) m_cnt = 0;
        end else if (a == 6'h04) begin
            if (d[0]) m_irq = 0;
        end else if (a == 6'h08) begin
            m_backdrop = nv & 32'h3F;
        end else if (a >= 6'h10 && int'(a) < 16 + 4 * NL && a[1:0] == 2'b00) begin
            m_scr[(int'(a) - 16) / 4] = nv & SCR_FIELDS;
        end
    endfunction

    function automatic void m_frame();
        if (!m_ctrl[0]) return;
        for (int i = 0; i < NL; i++) begin
            m_ax[i] = m_scr[i][SW-1:0];
            m_ay[i] = m_scr[i][16 +: SW];
        end
        m_cnt = (m_cnt + 1) % 256;
        m_irq = 1;
    endfunction

    function automatic logic [7:0] m_pixel(input logic vs, input logic hs, input logic vis,
                                           input logic [6*NL-1:0] rgb, input logic [NL-1:0] opq);
        logic [5:0] col;
        bit found;
        if (!m_ctrl[0]) return 8'h00;
        col = m_backdrop[5:0];
        found = 0;
        for (int i = 0; i < NL; i++) begin
            if (!found && m_ctrl[4+i] && opq[i]) begin col = rgb[6*i +: 6]; found = 1; end
        end
        if (!vis) col = 6'd0;
        return {vs, hs, col};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [1:0] wn, input bit vs_rise);
        bit fired;
        bus.address = a; bus.data_in = d; bus.data_write_n = wn;
        fired = 0;
        if (vs_rise) begin vsync = 1'b1; fired = m_ctrl[0]; end
        if (fired) m_frame();
        m_write(a, d, wn);
        if (fired) m_irq = 1;
        tick();
        bus.data_write_n = 2'b11;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic frame();
        vsync = 1'b1;
        m_frame();
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.address = 0; bus.data_in = 0; bus.data_write_n = 2'b11; bus.data_read_n = 2'b11;
        hsync = 0; vsync = 0; visible = 0; layer_rgb = 0; layer_opaque = 0;
        tick(); tick();
        reset = 1'b0;
        m_reset();
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [5:0] addrs [4];
        addrs[0] = 6'h00; addrs[1] = 6'h04; addrs[2] = 6'h08; addrs[3] = 6'h10;
        do_reset();
        foreach (addrs[k]) begin
            do_read(addrs[k], rd);
            tests_run++;
            if (rd !== 32'h0) begin fails++; $display("FAIL reset_read[%h]: got %h want 0", addrs[k], rd); end
        end
        tests_run++;
        if (uo_out !== 8'h00) begin fails++; $display("FAIL reset_uo: got %h want 00", uo_out); end
        tests_run++;
        if (user_interrupt !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", user_interrupt); end
        tests_run++;
        if (bus.data_ready !== 1'b1) begin fails++; $display("FAIL data_ready: got %b want 1", bus.data_ready); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, d;
        logic [5:0] a;
        logic [1:0] wn;
        do_reset();
        do_write(6'h10, 32'h0123_0155, 2'b10, 0);
        do_read(6'h10, rd);
        tests_run++;
        if (rd !== 32'h0123_0155) begin fails++; $display("FAIL lane32: got %h want 01230155", rd); end
        do_write(6'h10, 32'hFFFF_FFAA, 2'b00, 0);
        do_read(6'h10, rd);
        tests_run++;
        if (rd !== 32'h0123_01AA) begin fails++; $display("FAIL lane8: got %h want 012301AA", rd); end
        do_write(6'h10, 32'hFFFF_03FF, 2'b01, 0);
        do_read(6'h10, rd);
        tests_run++;
        if (rd !== 32'h0123_03FF) begin fails++; $display("FAIL lane16: got %h want 012303FF", rd); end
        for (int n = 0; n < 40; n++) begin
            a  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'(4 * $urandom_range(0, 7));
            d  = $urandom;
            wn = 2'($urandom_range(0, 3));
            do_write(a, d, wn, 0);
            do_read(a, rd);
            tests_run++;
            if (rd !== m_read(a)) begin fails++; $display("FAIL lane_rand[%h wn=%b]: got %h want %h", a, wn, rd, m_read(a)); end
        end
    endtask

    task automatic test_scroll();
        do_reset();
        do_write(6'h00, 32'h01, 2'b10, 0);
        do_write(6'h14, 32'h0000_0005, 2'b10, 0);
        tick(); tick();
        tests_run++;
        if (scroll_x[SW +: SW] !== 10'd0) begin fails++; $display("FAIL scroll_mid: got %0d want 0", scroll_x[SW +: SW]); end
        frame();
        tests_run++;
        if (scroll_x[SW +: SW] !== 10'd5) begin fails++; $display("FAIL scroll_latch: got %0d want 5", scroll_x[SW +: SW]); end
        do_write(6'h14, 32'h0000_0009, 2'b10, 1);
        vsync = 1'b0;
        tick();
        tests_run++;
        if (scroll_x[SW +: SW] !== 10'd5) begin fails++; $display("FAIL scroll_same_edge: got %0d want 5", scroll_x[SW +: SW]); end
        frame();
        tests_run++;
        if (scroll_x[SW +: SW] !== 10'd9) begin fails++; $display("FAIL scroll_next: got %0d want 9", scroll_x[SW +: SW]); end
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NL; i++) do_write(6'(16 + 4 * i), $urandom, 2'b10, 0);
            frame();
            for (int i = 0; i < NL; i++) begin
                tests_run++;
                if (scroll_x[SW*i +: SW] !== m_ax[i] || scroll_y[SW*i +: SW] !== m_ay[i]) begin
                    fails++;
                    $display("FAIL scroll_rand[%0d]: got x=%h y=%h want x=%h y=%h", i,
                             scroll_x[SW*i +: SW], scroll_y[SW*i +: SW], m_ax[i], m_ay[i]);
                end
            end
        end
        do_write(6'h00, 32'h00, 2'b10, 0);
        for (int i = 0; i < NL; i++) do_write(6'(16 + 4 * i), $urandom, 2'b10, 0);
        frame();
        for (int i = 0; i < NL; i++) begin
            tests_run++;
            if (scroll_x[SW*i +: SW] !== m_ax[i]) begin
                fails++; $display("FAIL scroll_hold[%0d]: got %h want %h", i, scroll_x[SW*i +: SW], m_ax[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic [7:0] exp;
        do_reset();
        do_write(6'h00, 32'hF1, 2'b10, 0);
        do_write(6'h08, 32'h03, 2'b10, 0);
        visible = 1; hsync = 0; vsync = 0;
        layer_rgb = {6'h00, 6'h15, 6'h2A, 6'h3F};
        layer_opaque = 4'b0110;
        tick();
        tests_run++;
        if (uo_out !== 8'h2A) begin fails++; $display("FAIL mix_layer1: got %h want 2A", uo_out); end
        layer_opaque = 4'b0000;
        tick();
        tests_run++;
        if (uo_out !== 8'h03) begin fails++; $display("FAIL mix_backdrop: got %h want 03", uo_out); end
        layer_opaque = 4'b1111;
        visible = 0;
        tick();
        tests_run++;
        if (uo_out !== 8'h00) begin fails++; $display("FAIL mix_invisible: got %h want 00", uo_out); end
        visible = 1; vsync = 1; hsync = 1;
        tick();
        tests_run++;
        if (uo_out !== 8'hFF) begin fails++; $display("FAIL mix_syncs: got %h want FF", uo_out); end
        vsync = 0;
        for (int n = 0; n < 40; n++) begin
            if (n % 5 == 0) do_write(6'h00, 32'(($urandom_range(0, 15) << 4) | 1), 2'b10, 0);
            if (n % 7 == 0) do_write(6'h08, $urandom, 2'b00, 0);
            layer_rgb = 24'($urandom);
            layer_opaque = 4'($urandom);
            visible = 1'($urandom_range(0, 3) != 0);
            hsync = 1'($urandom);
            exp = m_pixel(vsync, hsync, visible, layer_rgb, layer_opaque);
            tick();
            tests_run++;
            if (uo_out !== exp) begin fails++; $display("FAIL mix_rand[%0d]: got %h want %h", n, uo_out, exp); end
        end
        do_write(6'h00, 32'hF0, 2'b10, 0);
        hsync = 1; vsync = 1; visible = 1;
        tick();
        tests_run++;
        if (uo_out !== 8'h00) begin fails++; $display("FAIL mix_disabled: got %h want 00", uo_out); end
        vsync = 0; hsync = 0;
    endtask

    task automatic test_irq_frames();
        logic [31:0] rd;
        do_reset();
        do_write(6'h00, 32'h03, 2'b10, 0);
        vsync = 1'b1;
        m_frame();
        tick();
        tests_run++;
        if (user_interrupt !== 1'b1) begin fails++; $display("FAIL irq_first: got %b want 1", user_interrupt); end
        vsync = 1'b0;
        tick();
        frame(); frame();
        tests_run++;
        if (frame_count !== 8'd3) begin fails++; $display("FAIL count3: got %0d want 3", frame_count); end
        do_read(6'h04, rd);
        tests_run++;
        if (rd !== 32'h0000_0301) begin fails++; $display("FAIL status3: got %h want 00000301", rd); end
        do_write(6'h04, 32'h1, 2'b00, 1);
        vsync = 1'b0;
        tick();
        do_read(6'h04, rd);
        tests_run++;
        if (rd !== 32'h0000_0401 || rd !== m_read(6'h04)) begin fails++; $display("FAIL w1c_vs_set: got %h want 00000401", rd); end
        do_write(6'h04, 32'h1, 2'b00, 0);
        do_read(6'h04, rd);
        tests_run++;
        if (rd !== 32'h0000_0400) begin fails++; $display("FAIL w1c_clear: got %h want 00000400", rd); end
        tests_run++;
        if (user_interrupt !== 1'b0) begin fails++; $display("FAIL irq_cleared: got %b want 0", user_interrupt); end
        for (int f = 0; f < 252; f++) frame();
        tests_run++;
        if (frame_count !== 8'd0 || m_cnt != 0) begin fails++; $display("FAIL count_wrap: got %0d want 0", frame_count); end
        do_write(6'h04, 32'h1, 2'b00, 0);
        do_write(6'h00, 32'h01, 2'b10, 0);
        frame();
        tests_run++;
        if (user_interrupt !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b want 0", user_interrupt); end
        do_read(6'h04, rd);
        tests_run++;
        if (rd !== m_read(6'h04)) begin fails++; $display("FAIL status_masked: got %h want %h", rd, m_read(6'h04)); end
        do_write(6'h00, 32'h00, 2'b00, 0);
        tests_run++;
        if (frame_count !== 8'd0) begin fails++; $display("FAIL count_disable: got %0d want 0", frame_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        do_write(6'h00, 32'h13, 2'b10, 0);
        do_write(6'h08, 32'h3F, 2'b10, 0);
        do_write(6'h10, 32'h0007_0007, 2'b10, 0);
        frame();
        visible = 1; hsync = 1;
        tick();
        tests_run++;
        if (uo_out !== 8'h7F || user_interrupt !== 1'b1) begin
            fails++; $display("FAIL pre_reset: got uo=%h irq=%b want uo=7F irq=1", uo_out, user_interrupt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || frame_count !== 8'd0 ||
            scroll_x !== '0 || scroll_y !== '0 || layer_en !== '0) begin
            fails++;
            $display("FAIL async_reset: got uo=%h irq=%b cnt=%0d sx=%h en=%b want all 0",
                     uo_out, user_interrupt, frame_count, scroll_x, layer_en);
        end
        m_reset();
        vsync = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_write(6'h00, 32'h03, 2'b10, 0);
        tick(); tick();
        tests_run++;
        if (frame_count !== 8'd0) begin fails++; $display("FAIL no_stale_rise: got %0d want 0", frame_count); end
        vsync = 1'b0;
        tick();
        frame();
        tests_run++;
        if (frame_count !== 8'd1) begin fails++; $display("FAIL fresh_rise: got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_scroll();
        test_priority();
        test_irq_frames();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
